// File: rtl/inst_decode_stage.sv
// RV32 instruction-decode stage: valid/ready input, single registered output slot.
// Optional illegal-instruction detection is built only when DEC_ILLEGAL_CHECK_EN is defined.
module inst_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    fmt_t            fmt_d;
    logic [XLEN-1:0] imm_d;
    logic            accept;
    logic            out_fire;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        fmt_d = FMT_X;
        case (instruction[6:0])
            OP_REG:                                   fmt_d = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:      fmt_d = FMT_I;
            OP_STORE:                                 fmt_d = FMT_S;
            OP_BRANCH:                                fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:                         fmt_d = FMT_U;
            OP_JAL:                                   fmt_d = FMT_J;
            default:                                  fmt_d = FMT_X;
        endcase
    end

    // Size casts of signed operands sign-extend to XLEN.
    always_comb begin
        imm_d = '0;
        case (fmt_d)
            FMT_I: imm_d = XLEN'($signed(instruction[31:20]));
            FMT_S: imm_d = XLEN'($signed({instruction[31:25], instruction[11:7]}));
            FMT_B: imm_d = XLEN'($signed({instruction[31], instruction[7],
                                          instruction[30:25], instruction[11:8], 1'b0}));
            FMT_U: imm_d = XLEN'($signed({instruction[31:12], 12'b0}));
            FMT_J: imm_d = XLEN'($signed({instruction[31], instruction[19:12],
                                          instruction[20], instruction[30:21], 1'b0}));
            default: imm_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            rd        <= '0;
            funct3    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct7    <= '0;
            imm       <= '0;
            fmt       <= '0;
            dec_count <= '0;
        end else begin
            if (out_fire && (dec_count != '1))
                dec_count <= dec_count + CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                opcode    <= instruction[6:0];
                rd        <= instruction[11:7];
                funct3    <= instruction[14:12];
                rs1       <= instruction[19:15];
                rs2       <= instruction[24:20];
                funct7    <= instruction[31:25];
                imm       <= imm_d;
                fmt       <= fmt_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DEC_ILLEGAL_CHECK_EN
    logic illegal_d;

    assign illegal_d = (fmt_d == FMT_X) || (instruction[1:0] != 2'b11) || (instruction == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal <= 1'b0;
        else if (!flush && accept)
            illegal <= illegal_d;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: vector table, hand sequences and random traffic
// against a behavioural model; three DUTs (default, XLEN=64, CNT_W=2) share stimulus.
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, illegal;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, fmt;
    logic [31:0] imm;
    logic [15:0] dec_count;

    logic        in_ready64, out_valid64, illegal64;
    logic [6:0]  opcode64, funct764;
    logic [4:0]  rd64, rs164, rs264;
    logic [2:0]  funct364, fmt64;
    logic [63:0] imm64;
    logic [15:0] dec_count64;

    logic        in_ready2, out_valid2, illegal2;
    logic [6:0]  opcode2, funct72;
    logic [4:0]  rd2, rs12, rs22;
    logic [2:0]  funct32, fmt2;
    logic [31:0] imm2;
    logic [1:0]  dec_count2;

    always #5 clk = ~clk;

    inst_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm), .fmt(fmt),
        .illegal(illegal), .dec_count(dec_count));

    inst_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready), .opcode(opcode64), .rd(rd64), .funct3(funct364),
        .rs1(rs164), .rs2(rs264), .funct7(funct764), .imm(imm64), .fmt(fmt64),
        .illegal(illegal64), .dec_count(dec_count64));

    inst_decode_stage #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .instruction(instruction), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .opcode(opcode2), .rd(rd2), .funct3(funct32),
        .rs1(rs12), .rs2(rs22), .funct7(funct72), .imm(imm2), .fmt(fmt2),
        .illegal(illegal2), .dec_count(dec_count2));

    typedef struct {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        ill;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    exp_t m;
    logic m_valid;
    int   m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the format rules with signed integer arithmetic.
    function automatic exp_t decode(input logic [31:0] i);
        exp_t   e;
        longint s, v;
        s = longint'($signed(i));
        e.opcode = i[6:0];
        e.rd     = i[11:7];
        e.funct3 = i[14:12];
        e.rs1    = i[19:15];
        e.rs2    = i[24:20];
        e.funct7 = i[31:25];
        case (i[6:0])
            7'h33:                      e.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h23:                      e.fmt = 3'd2;
            7'h63:                      e.fmt = 3'd3;
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            default:                    e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: v = s >>> 20;
            3'd2: v = (s >>> 25) * 32 + longint'(i[11:7]);
            3'd3: v = (s >>> 31) * 4096 + longint'(i[7]) * 2048
                      + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            3'd4: v = (s >>> 12) * 4096;
            3'd5: v = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
                      + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: v = 0;
        endcase
        e.imm = 64'(v);
`ifdef DEC_ILLEGAL_CHECK_EN
        e.ill = (e.fmt == 3'd7) || (i[1:0] != 2'b11) || (i == 32'h0);
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_valid = 1'b0;
        m_cnt = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("opcode", 64'(opcode), 64'(m.opcode));
        chk("rd", 64'(rd), 64'(m.rd));
        chk("funct3", 64'(funct3), 64'(m.funct3));
        chk("rs1", 64'(rs1), 64'(m.rs1));
        chk("rs2", 64'(rs2), 64'(m.rs2));
        chk("funct7", 64'(funct7), 64'(m.funct7));
        chk("imm", 64'(imm), 64'(m.imm[31:0]));
        chk("imm64", imm64, m.imm);
        chk("fmt", 64'(fmt), 64'(m.fmt));
        chk("illegal", 64'(illegal), 64'(m.ill));
        chk("dec_count", 64'(dec_count), 64'((m_cnt > 65535) ? 65535 : m_cnt));
        chk("dec_count2", 64'(dec_count2), 64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // One clock: drive inputs, check in_ready, advance, update model, check outputs.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        logic exp_ready;
        in_valid = iv;
        instruction = ins;
        out_ready = ordy;
        flush = fl;
        #1;
        exp_ready = !fl && (!m_valid || ordy);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (m_valid && ordy) m_cnt++;
        if (fl) m_valid = 1'b0;
        else if (iv && exp_ready) begin
            m_valid = 1'b1;
            m = decode(ins);
        end else if (ordy) m_valid = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    vec_t vecs [11];
    int   sat_exp [5];
    logic exp_ill;

    initial begin
        vecs[0]  = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 1'b0};
        vecs[1]  = '{32'h0051A423, 3'd2, 32'h00000008, 5'd8, 5'd3, 5'd5, 3'd2, 7'h00, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 1'b0};
        vecs[3]  = '{32'h123452B7, 3'd4, 32'h12345000, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 1'b0};
        vecs[4]  = '{32'h008000EF, 3'd5, 32'h00000008, 5'd1, 5'd0, 5'd8, 3'd0, 7'h00, 1'b0};
        vecs[5]  = '{32'h002081B3, 3'd0, 32'h00000000, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 1'b0};
        vecs[6]  = '{32'h00412083, 3'd1, 32'h00000004, 5'd1, 5'd2, 5'd4, 3'd2, 7'h00, 1'b0};
        vecs[7]  = '{32'h800000B7, 3'd4, 32'h80000000, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40, 1'b0};
        vecs[8]  = '{32'h00000000, 3'd7, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b1};
        vecs[9]  = '{32'h0000007F, 3'd7, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b1};
        vecs[10] = '{32'h00000013, 3'd1, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3};

        do_reset();

        // Single addi: one-cycle latency, then counted on the output handshake.
        cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_count", 64'(dec_count), 64'd1);

        foreach (vecs[k]) begin
            cycle(1'b1, vecs[k].instr, 1'b1, 1'b0);
`ifdef DEC_ILLEGAL_CHECK_EN
            exp_ill = vecs[k].ill;
`else
            exp_ill = 1'b0;
`endif
            chk("tbl_fmt", 64'(fmt), 64'(vecs[k].fmt));
            chk("tbl_imm", 64'(imm), 64'(vecs[k].imm));
            chk("tbl_imm64", imm64, {{32{vecs[k].imm[31]}}, vecs[k].imm});
            chk("tbl_rd", 64'(rd), 64'(vecs[k].rd));
            chk("tbl_rs1", 64'(rs1), 64'(vecs[k].rs1));
            chk("tbl_rs2", 64'(rs2), 64'(vecs[k].rs2));
            chk("tbl_funct3", 64'(funct3), 64'(vecs[k].funct3));
            chk("tbl_funct7", 64'(funct7), 64'(vecs[k].funct7));
            chk("tbl_illegal", 64'(illegal), 64'(exp_ill));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall: A held for three cycles with B waiting, then B follows exactly once.
        do_reset();
        cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 32'h123452B7, 1'b0, 1'b0);
            chk("stall_rd", 64'(rd), 64'd1);
            chk("stall_imm", 64'(imm), 64'hFFFFFFFF);
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        cycle(1'b1, 32'h123452B7, 1'b1, 1'b0);
        chk("stall_b_rd", 64'(rd), 64'd5);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall_valid", 64'(out_valid), 64'd0);
        chk("stall_count", 64'(dec_count), 64'd2);

        // Flush with held output: input dropped; counted only when out_ready was high.
        do_reset();
        cycle(1'b1, 32'hFFF10093, 1'b0, 1'b0);
        cycle(1'b1, 32'h123452B7, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(dec_count), 64'd0);
        chk("flush_rd", 64'(rd), 64'd1);
        cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
        cycle(1'b1, 32'h123452B7, 1'b1, 1'b1);
        chk("flush_valid2", 64'(out_valid), 64'd0);
        chk("flush_count2", 64'(dec_count), 64'd1);

        // Reset asserted mid-stall clears outputs before the next edge.
        cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        cycle(1'b1, 32'h0051A423, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        #1 rst = 1'b0;
        cycle(1'b1, 32'h0051A423, 1'b1, 1'b0);

        // Two-bit counter saturates.
        do_reset();
        cycle(1'b1, rand_instr(), 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, rand_instr(), 1'b1, 1'b0);
            chk("sat_count2", 64'(dec_count2), 64'(sat_exp[n]));
        end

        do_reset();
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 11) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
